instruction_cache: RTL and testbench

Direct-mapped, read-only instruction cache between the PC register and the instruction decode / control unit. It returns the 32-bit instruction addressed by the PC in the same cycle on a hit. On a miss it asserts INS_BUSYWAIT, which the control unit folds into HOLD to stall the PC, and it fetches a 128-bit block from instruction memory. Capacity is 8 blocks × 4 instructions, covering a 1 KB instruction space (PC[9:0]).

---
 rtl/instruction_cache_pkg.sv | 25 ++
 rtl/icache_line_array.sv | 47 ++++
 rtl/instruction_cache.sv | 99 +++++++++
 tb/tb_instruction_cache.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/instruction_cache_pkg.sv
// Shared constants, PC field positions and FSM encoding
// for the direct-mapped instruction cache.
package instruction_cache_pkg;

    localparam int NUM_BLOCKS      = 8;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int TAG_W           = 3;
    localparam int BLOCK_ADDR_W    = 6;

    localparam int IDX_W  = $clog2(NUM_BLOCKS);
    localparam int OFF_W  = $clog2(WORDS_PER_BLOCK);
    localparam int WORD_W = 32;
    localparam int LINE_W = WORD_W * WORDS_PER_BLOCK;

    localparam int OFF_LSB = 2;
    localparam int IDX_LSB = OFF_LSB + OFF_W;
    localparam int TAG_LSB = IDX_LSB + IDX_W;
    localparam int BLK_LSB = IDX_LSB;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage: one fill write port and a
// combinational read port returning hit and selected word.
module icache_line_array
    import instruction_cache_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [TAG_W-1:0]  i_wr_tag,
    input  logic [LINE_W-1:0] i_wr_data,
    input  logic [IDX_W-1:0]  i_rd_idx,
    input  logic [TAG_W-1:0]  i_rd_tag,
    input  logic [OFF_W-1:0]  i_rd_off,
    output logic              o_hit,
    output logic [WORD_W-1:0] o_word
);

    logic [NUM_BLOCKS-1:0] r_valid;
    logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
    logic [LINE_W-1:0]     r_data [NUM_BLOCKS];

    logic [LINE_W-1:0] w_line;
    logic [6:0]        w_bit_base;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_wr_idx] <= 1'b1;
        end
    end

    // Tag and data are not reset; the valid bit gates their use.
    always_ff @(posedge i_clk) begin
        if (!i_rst && i_we) begin
            r_tag[i_wr_idx]  <= i_wr_tag;
            r_data[i_wr_idx] <= i_wr_data;
        end
    end

    assign w_line     = r_data[i_rd_idx];
    assign w_bit_base = {i_rd_off, 5'b0};
    assign o_word     = w_line[w_bit_base +: WORD_W];
    assign o_hit      = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: zero-cycle hits,
// stalls the PC and fetches a 128-bit block on a miss.
module instruction_cache
    import instruction_cache_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [31:0]             PC,
    output logic [31:0]             INSTRUCTION,
    output logic                    INS_BUSYWAIT,
    output logic                    MEM_READ,
    output logic [BLOCK_ADDR_W-1:0] MEM_ADDRESS,
    input  logic [LINE_W-1:0]       MEM_READDATA,
    input  logic                    MEM_BUSYWAIT
);

    state_t r_state;
    state_t w_next;

    logic [BLOCK_ADDR_W-1:0] r_fill_addr;

    logic [OFF_W-1:0]        w_off;
    logic [IDX_W-1:0]        w_idx;
    logic [TAG_W-1:0]        w_tag;
    logic [BLOCK_ADDR_W-1:0] w_blk;
    logic                    w_hit;
    logic                    w_we;
    logic                    w_busy;
    logic                    w_read;
    logic                    w_unused_pc;

    assign w_off = PC[IDX_LSB-1:OFF_LSB];
    assign w_idx = PC[TAG_LSB-1:IDX_LSB];
    assign w_tag = PC[TAG_LSB+TAG_W-1:TAG_LSB];
    assign w_blk = PC[BLK_LSB+BLOCK_ADDR_W-1:BLK_LSB];

    assign w_unused_pc = ^{PC[31:TAG_LSB+TAG_W], PC[OFF_LSB-1:0]};

    icache_line_array u_lines (
        .i_clk     (CLK),
        .i_rst     (RESET),
        .i_we      (w_we),
        .i_wr_idx  (r_fill_addr[IDX_W-1:0]),
        .i_wr_tag  (r_fill_addr[BLOCK_ADDR_W-1:IDX_W]),
        .i_wr_data (MEM_READDATA),
        .i_rd_idx  (w_idx),
        .i_rd_tag  (w_tag),
        .i_rd_off  (w_off),
        .o_hit     (w_hit),
        .o_word    (INSTRUCTION)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= S_IDLE;
            r_fill_addr <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && !w_hit) begin
                r_fill_addr <= w_blk;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_read = 1'b0;
        w_we   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_busy = !w_hit;
                if (!w_hit) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_busy = 1'b1;
                w_read = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    w_we   = 1'b1;
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        // Reset dominates: quiet interface and no fill commit.
        if (RESET) begin
            w_busy = 1'b0;
            w_read = 1'b0;
            w_we   = 1'b0;
        end
    end

    assign INS_BUSYWAIT = w_busy;
    assign MEM_READ     = w_read;
    assign MEM_ADDRESS  = RESET ? '0 : r_fill_addr;

endmodule

// File: tb/tb_instruction_cache.sv
// Directed self-checking bench for instruction_cache with a
// small latency-programmable block memory model.
module tb_instruction_cache;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         INS_BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    int n_checks = 0;
    int n_errors = 0;
    int mem_lat  = 4;
    int mem_cnt  = 0;

    instruction_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .INS_BUSYWAIT (INS_BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Word w of block b reads as 0xA000_0000 | b<<8 | w.
    always_comb begin
        MEM_READDATA = '0;
        for (int w = 0; w < 4; w++) begin
            MEM_READDATA[w*32 +: 32] = 32'hA000_0000
                | ({26'd0, MEM_ADDRESS} << 8) | w;
        end
    end

    assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < mem_lat);

    always_ff @(posedge CLK) begin
        if (MEM_READ) mem_cnt <= mem_cnt + 1;
        else          mem_cnt <= 0;
    end

    task automatic check(input string tag,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_fill();
        int n = 0;
        while (INS_BUSYWAIT && n < 50) begin
            tick();
            n++;
        end
        check("fill_done", {31'd0, INS_BUSYWAIT}, 32'd0);
    endtask

    task automatic hit(input logic [31:0] pc, input logic [31:0] exp);
        PC = pc;
        #1;
        check("hit_busy", {31'd0, INS_BUSYWAIT}, 32'd0);
        check("hit_read", {31'd0, MEM_READ}, 32'd0);
        check("hit_instr", INSTRUCTION, exp);
        tick();
    endtask

    initial begin
        int nb;
        RESET = 1'b1;
        PC    = 32'h0;
        tick();
        tick();
        check("rst_busy", {31'd0, INS_BUSYWAIT}, 32'd0);
        check("rst_read", {31'd0, MEM_READ}, 32'd0);
        check("rst_addr", {26'd0, MEM_ADDRESS}, 32'd0);
        RESET = 1'b0;

        // Cold miss, memory busy for 4 cycles
        #1;
        check("cold_busy", {31'd0, INS_BUSYWAIT}, 32'd1);
        check("cold_noread", {31'd0, MEM_READ}, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("cold_f_busy", {31'd0, INS_BUSYWAIT}, 32'd1);
            check("cold_f_read", {31'd0, MEM_READ}, 32'd1);
            check("cold_f_addr", {26'd0, MEM_ADDRESS}, 32'd0);
            tick();
        end
        check("cold_done", {31'd0, INS_BUSYWAIT}, 32'd0);
        check("cold_instr", INSTRUCTION, 32'hA000_0000);

        // Same-line hits
        hit(32'h004, 32'hA000_0001);
        hit(32'h008, 32'hA000_0002);
        hit(32'h00C, 32'hA000_0003);

        // Conflict miss on index 0
        PC = 32'h080;
        #1;
        check("conf_busy", {31'd0, INS_BUSYWAIT}, 32'd1);
        tick();
        check("conf_read", {31'd0, MEM_READ}, 32'd1);
        check("conf_addr", {26'd0, MEM_ADDRESS}, 32'h08);
        wait_fill();
        check("conf_instr", INSTRUCTION, 32'hA000_0800);
        tick();
        PC = 32'h000;
        #1;
        check("evict_busy", {31'd0, INS_BUSYWAIT}, 32'd1);
        tick();
        check("evict_addr", {26'd0, MEM_ADDRESS}, 32'h00);
        wait_fill();
        check("evict_instr", INSTRUCTION, 32'hA000_0000);
        tick();

        // Independent lines 0 and 1
        PC = 32'h010;
        #1;
        check("l1_busy", {31'd0, INS_BUSYWAIT}, 32'd1);
        tick();
        wait_fill();
        tick();
        hit(32'h000, 32'hA000_0000);
        hit(32'h010, 32'hA000_0100);
        hit(32'h004, 32'hA000_0001);
        hit(32'h01C, 32'hA000_0103);

        // Reset in the middle of a fill
        PC = 32'h020;
        #1;
        tick();
        tick();
        check("mid_read", {31'd0, MEM_READ}, 32'd1);
        RESET = 1'b1;
        #1;
        check("mid_rst_read", {31'd0, MEM_READ}, 32'd0);
        check("mid_rst_busy", {31'd0, INS_BUSYWAIT}, 32'd0);
        check("mid_rst_addr", {26'd0, MEM_ADDRESS}, 32'd0);
        tick();
        RESET = 1'b0;
        #1;
        check("mid_remiss", {31'd0, INS_BUSYWAIT}, 32'd1);
        tick();
        check("mid_refetch", {26'd0, MEM_ADDRESS}, 32'h02);
        wait_fill();
        check("mid_instr", INSTRUCTION, 32'hA000_0200);
        tick();
        // line 0 lost its valid bit in the reset
        PC = 32'h000;
        #1;
        check("mid_l0_invalid", {31'd0, INS_BUSYWAIT}, 32'd1);
        tick();
        wait_fill();
        tick();

        // Zero-latency memory
        mem_lat = 0;
        PC = 32'h030;
        #1;
        nb = 0;
        while (INS_BUSYWAIT && nb < 20) begin
            nb++;
            tick();
        end
        check("zl_busy_cycles", nb, 32'd2);
        check("zl_instr", INSTRUCTION, 32'hA000_0300);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
